// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 16-way round-robin arbiter:
//   - NUM_REQ / SEL_W : requester count and select width
//   - arb_state_t     : arbiter FSM states
//   - rr_pick()       : round-robin priority pick returning {found, idx}
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Search order is ptr+1, ptr+2, ... ptr (4-bit wrap), so the last
    // grantee is the lowest priority. Scanning from the far end and letting
    // the later (nearer) hit overwrite gives the nearest requester.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux16.sv
// ----------------------------------------------------------------------------
// mux16
// 16:1 payload multiplexer.
//   sel      in  4          index of the slice to forward
//   data_in  in  16*width   slice i at [i*width +: width]
//   data_out out width      selected slice (combinational)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mux16
    import arb_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_REQ*width-1:0] data_in,
    output logic [width-1:0]         data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out = data_in[i*width +: width];
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter sharing one downstream resource among 16 requesters.
// Holds a grant until the resource pulses done, re-arbitrates back-to-back on
// completion, and releases a hung grant after TIMEOUT cycles.
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   req         in   16  request vector (bit i = requester i)
//   data_in     in   16*width payloads, requester i at [i*width +: width]
//   done        in   resource completed the current transaction
//   sel         out  4   current grantee index (mux16 select)
//   grant       out  16  one-hot grant, zero when idle
//   busy        out  a grant is active
//   data_out    out  width payload of the selected requester
//   ack         out  16  one-hot completion pulse to the grantee
//   timeout_err out  1-cycle pulse when the watchdog releases a grant
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mux16_rr_arbiter
    import arb_pkg::*;
#(
    parameter int width   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*width-1:0] data_in,
    input  logic                     done,
    output logic [SEL_W-1:0]         sel,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [width-1:0]         data_out,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     timeout_err
);

    localparam int WDOG_W = $clog2(TIMEOUT) + 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [SEL_W:0]       pick;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
        pick          = '0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(req, ptr_q);
                if (pick[SEL_W]) begin
                    grant_d = NUM_REQ'(1) << pick[SEL_W-1:0];
                    sel_d   = pick[SEL_W-1:0];
                    ptr_d   = pick[SEL_W-1:0];
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
                if (done) begin
                    // The finished requester still holds req this cycle, so
                    // mask it out before picking the next winner.
                    pick = rr_pick(req & ~grant_q, ptr_q);
                    if (pick[SEL_W]) begin
                        grant_d = NUM_REQ'(1) << pick[SEL_W-1:0];
                        sel_d   = pick[SEL_W-1:0];
                        ptr_d   = pick[SEL_W-1:0];
                        wdog_d  = '0;
                    end else begin
                        grant_d = '0;
                        wdog_d  = '0;
                        state_d = IDLE;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // Hung grant: release it; ptr keeps the hung requester
                    // so it becomes lowest priority next round.
                    grant_d       = '0;
                    wdog_d        = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            ptr_q         <= 4'hF;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign sel         = sel_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;
    assign ack         = grant_q & {NUM_REQ{done & busy}};

    mux16 #(.width(width)) u_mux16 (
        .sel      (sel_q),
        .data_in  (data_in),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux16_rr_arbiter
// Directed bench for mux16_rr_arbiter with a behavioural reference model and
// per-cycle comparison of all outputs.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux16_rr_arbiter;

    localparam int W  = 32;
    localparam int TO = 64;

    logic           clk;
    logic           rst;
    logic [15:0]    req;
    logic [16*W-1:0] data_in;
    logic           done;
    logic [3:0]     sel;
    logic [15:0]    grant;
    logic           busy;
    logic [W-1:0]   data_out;
    logic [15:0]    ack;
    logic           timeout_err;

    logic [W-1:0]   din [16];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner = current grantee (-1 when idle),
    // last = most recent grantee, held = cycles the current grant has lasted.
    int m_owner;
    int m_last;
    int m_sel;
    int m_held;
    bit m_terr;

    mux16_rr_arbiter #(.width(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .busy        (busy),
        .data_out    (data_out),
        .ack         (ack),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 16; i++) data_in[i*W +: W] = din[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int next_winner(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (r[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_last = 15; m_sel = 0; m_held = 0; m_terr = 0;
        end else begin
            int w;
            m_terr = 0;
            if (m_owner < 0) begin
                w = next_winner(req, m_last);
                if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_held = 1; end
            end else if (done) begin
                w = next_winner(req & ~(16'(1) << m_owner), m_last);
                if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_held = 1; end
                else m_owner = -1;
            end else if (m_held == TO) begin
                m_owner = -1; m_terr = 1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [15:0] eg;
            eg = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0;
            check("grant", grant, eg);
            check("busy", busy, (m_owner >= 0));
            check("sel", sel, 64'(m_sel));
            check("ack", ack, (done && m_owner >= 0) ? eg : 16'h0);
            check("timeout_err", timeout_err, m_terr);
            if (m_owner >= 0) check("data_out", data_out, din[m_sel]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        for (int i = 0; i < 16; i++) din[i] = 32'h1000_0000 + i;
        repeat (2) @(posedge clk);
        #2;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_terr", timeout_err, 0);
        rst = 1'b0;

        // done while idle is ignored
        done = 1'b1; #1 check("idle_done_ack", ack, 0);
        tick(); done = 1'b0;
        check("idle_done_terr", timeout_err, 0);
        check("idle_done_busy", busy, 0);

        // single request
        req = 16'h0001; tick();
        check("single_grant", grant, 16'h0001);
        check("single_sel", sel, 0);
        check("single_busy", busy, 1);
        done = 1'b1; #1 check("single_ack", ack, 16'h0001);
        tick(); done = 1'b0; req = '0;
        check("single_release_busy", busy, 0);
        check("single_release_grant", grant, 0);

        // full round robin, done every 3rd cycle, back-to-back grants
        req = 16'hFFFF; tick();
        for (int g = 0; g < 16; g++) begin
            check("rr_sel", sel, 64'((g + 1) % 16));
            check("rr_busy", busy, 1);
            tick(); tick();
            done = 1'b1;
            #1 check("rr_ack", ack, 64'(16'(1) << ((g + 1) % 16)));
            tick(); done = 1'b0;
        end
        check("rr_wrap_sel", sel, 1);
        req = '0; done = 1'b1; tick(); done = 1'b0;

        // last grantee 5 is lowest priority
        req = 16'h0020; tick();
        check("ptr5_setup_sel", sel, 5);
        done = 1'b1; tick(); done = 1'b0; req = '0;
        req = 16'h0021; tick();
        check("ptr5_grant0", grant, 16'h0001);
        done = 1'b1; #1 check("ptr5_ack0", ack, 16'h0001);
        tick(); done = 1'b0; req = 16'h0020;
        check("ptr5_then5", grant, 16'h0020);
        check("ptr5_then5_busy", busy, 1);
        done = 1'b1; tick(); done = 1'b0; req = '0;
        check("ptr5_idle", busy, 0);

        // watchdog release after TIMEOUT cycles
        req = 16'h0008; tick();
        check("wd_grant3", grant, 16'h0008);
        req = 16'h0208;
        repeat (TO - 1) tick();
        check("wd_hold", grant, 16'h0008);
        check("wd_no_err_yet", timeout_err, 0);
        tick();
        check("wd_terr", timeout_err, 1);
        check("wd_grant0", grant, 0);
        check("wd_busy0", busy, 0);
        check("wd_ack0", ack, 0);
        tick();
        check("wd_next9", sel, 9);
        check("wd_terr_pulse", timeout_err, 0);
        req = '0; done = 1'b1; tick(); done = 1'b0;

        // done on the timeout cycle wins
        req = 16'h0010; tick();
        repeat (TO - 1) tick();
        done = 1'b1; #1 check("wd_done_ack", ack, 16'h0010);
        tick(); done = 1'b0; req = '0;
        check("wd_done_noerr", timeout_err, 0);
        check("wd_done_idle", busy, 0);

        // payload routing
        din[7] = 32'hDEADBEEF;
        req = 16'h0080; tick();
        check("mux_data", data_out, 32'hDEADBEEF);
        din[7] = 32'h12345678;
        #1 check("mux_data_live", data_out, 32'h12345678);
        req = '0; done = 1'b1; tick(); done = 1'b0;

        // asynchronous reset mid-transaction
        req = 16'h0400; tick();
        check("ar_grant", grant, 16'h0400);
        #1 rst = 1'b1;
        #1;
        check("ar_grant0", grant, 0);
        check("ar_busy0", busy, 0);
        check("ar_sel0", sel, 0);
        check("ar_terr0", timeout_err, 0);
        tick();
        rst = 1'b0; req = 16'h0801; tick();
        check("ar_ptr_reset", grant, 16'h0001);
        req = '0; done = 1'b1; tick(); done = 1'b0;
        req = 16'h0400; tick();
        check("ar_regrant", grant, 16'h0400);
        req = '0; done = 1'b1; tick(); done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
